// File: rtl/div_radix2_iter.sv
// Multi-cycle restoring radix-2 divider driven by the EX-stage divider handshake.
// Takes unsigned magnitudes plus sign flags and returns sign-corrected
// quotient/remainder after WIDTH iterations, with a one-cycle div_done pulse.
// Optional feature macro: DIV_FAST_EN -- when defined, a zero divisor or a
// dividend smaller than the divisor finishes straight from IDLE (done at t+1).
`timescale 1ns/1ps

module div_radix2_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_begin,
  input  logic             div_sign,
  input  logic             div_dividend_sign,
  input  logic [WIDTH-1:0] div_dividend,
  input  logic [WIDTH-1:0] div_divisor,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder,
  output logic             div_done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;      // starts as the dividend, fills with quotient bits
  logic [WIDTH-1:0] divisor_q;
  logic             sign_q;
  logic             dividend_sign_q;

  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             last_iter;

  // Two's-complement negate when the flag is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] val);
    return neg ? (~val + WIDTH'(1)) : val;
  endfunction

  // One restoring step: shift {rem,quo} left, trial-subtract divisor at WIDTH+1 bits.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, divisor_q});
    rem_next  = rem_ge ? WIDTH'(rem_shift - {1'b0, divisor_q}) : rem_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], rem_ge};
    last_iter = (count_q == CW'(WIDTH - 1));
  end

  // Control FSM with iteration registers and registered results/done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      count_q         <= '0;
      rem_q           <= '0;
      quo_q           <= '0;
      divisor_q       <= '0;
      sign_q          <= 1'b0;
      dividend_sign_q <= 1'b0;
      div_quotient    <= '0;
      div_remainder   <= '0;
      div_done        <= 1'b0;
    end else begin
      div_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (div_begin) begin
            sign_q          <= div_sign;
            dividend_sign_q <= div_dividend_sign;
            divisor_q       <= div_divisor;
            quo_q           <= div_dividend;
            rem_q           <= '0;
            count_q         <= '0;
`ifdef DIV_FAST_EN
            // Trivial cases resolve without iterating.
            if ((div_divisor == '0) || (div_dividend < div_divisor)) begin
              div_quotient  <= neg_if(div_sign,
                                      (div_divisor == '0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}});
              div_remainder <= neg_if(div_dividend_sign, div_dividend);
              div_done      <= 1'b1;
              state_q       <= StDone;
            end else begin
              state_q <= StBusy;
            end
`else
            state_q <= StBusy;
`endif
          end
        end

        StBusy: begin
          if (!div_begin) begin
            // Pipeline flush: drop the operation, keep previous results.
            state_q <= StIdle;
          end else begin
            rem_q   <= rem_next;
            quo_q   <= quo_next;
            count_q <= count_q + CW'(1);
            if (last_iter) begin
              div_quotient  <= neg_if(sign_q, quo_next);
              div_remainder <= neg_if(dividend_sign_q, rem_next);
              div_done      <= 1'b1;
              count_q       <= '0;
              state_q       <= StDone;
            end
          end
        end

        StDone: begin
          // div_begin is ignored here; a held request restarts from IDLE.
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2_iter.sv
// Scoreboard bench for div_radix2_iter: driver pushes expected results and
// completion cycle, a negedge monitor pops and compares on every div_done.
`timescale 1ns/1ps

module tb_div_radix2_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         div_begin;
  logic         div_sign;
  logic         div_dividend_sign;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;
  logic         div_done;

  div_radix2_iter #(.WIDTH(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .div_begin         (div_begin),
    .div_sign          (div_sign),
    .div_dividend_sign (div_dividend_sign),
    .div_dividend      (div_dividend),
    .div_divisor       (div_divisor),
    .div_quotient      (div_quotient),
    .div_remainder     (div_remainder),
    .div_done          (div_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           done_cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with the documented divide-by-zero result.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic ds, input int t);
    exp_t e;
    int   lat;
    e.q = (b == 0) ? {W{1'b1}} : a / b;
    e.r = (b == 0) ? a : a % b;
    if (s)  e.q = -e.q;
    if (ds) e.r = -e.r;
    lat = W + 1;
`ifdef DIV_FAST_EN
    if (b == 0 || a < b) lat = 1;
`endif
    e.done_cyc = t + lat;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (div_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none (q=%0h r=%0h)",
                 cyc, div_quotient, div_remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 64'(div_quotient), 64'(e.q));
        chk("remainder", 64'(div_remainder), 64'(e.r));
        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
        last_q = e.q;
        last_r = e.r;
      end
    end
  end

  // Start an operation at the current negedge; b2b means we are in the DONE cycle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic ds, input bit b2b);
    int t;
    div_dividend      = a;
    div_divisor       = b;
    div_sign          = s;
    div_dividend_sign = ds;
    div_begin         = 1'b1;
    t = b2b ? cyc + 1 : cyc;
    sb.push_back(model(a, b, s, ds, t));
  endtask

  task automatic wait_done();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (div_done) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        sb.delete();
        break;
      end
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic s, input logic ds, input bit b2b);
    if (!b2b) begin
      div_begin = 1'b0;
      @(negedge clk);
    end
    start_op(a, b, s, ds, b2b);
    wait_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b;
    rst               = 1'b1;
    div_begin         = 1'b0;
    div_sign          = 1'b0;
    div_dividend_sign = 1'b0;
    div_dividend      = '0;
    div_divisor       = '0;
    repeat (3) @(negedge clk);
    chk("reset_q", 64'(div_quotient), 64'h0);
    chk("reset_r", 64'(div_remainder), 64'h0);
    chk("reset_done", 64'(div_done), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    run(32'd7,   32'd2, 1'b1, 1'b1, 1'b0);
    run(32'd5,   32'd0, 1'b0, 1'b0, 1'b0);
    run(32'd20,  32'd3, 1'b0, 1'b0, 1'b0);
    run(32'd17,  32'd5, 1'b0, 1'b0, 1'b1);

    // Abort: drop div_begin 10 cycles into the operation.
    div_begin = 1'b0;
    @(negedge clk);
    div_dividend      = 32'hFFFF_FFFF;
    div_divisor       = 32'd3;
    div_sign          = 1'b0;
    div_dividend_sign = 1'b0;
    div_begin         = 1'b1;
    repeat (10) @(negedge clk);
    div_begin = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_q_kept", 64'(div_quotient), 64'(last_q));
    chk("abort_r_kept", 64'(div_remainder), 64'(last_r));

    // Reset 20 cycles into an operation, then restart.
    div_dividend = 32'd1000;
    div_divisor  = 32'd3;
    div_begin    = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_q", 64'(div_quotient), 64'h0);
    chk("midrst_r", 64'(div_remainder), 64'h0);
    chk("midrst_done", 64'(div_done), 64'h0);
    rst    = 1'b0;
    last_q = '0;
    last_r = '0;
    run(32'd9, 32'd4, 1'b0, 1'b0, 1'b0);

    // Randomized operations, mixing trivial, small and full-range divisors.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 50);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = $urandom_range(1, 15);
        2:       b = $urandom;
        default: b = a + $urandom_range(0, 5);
      endcase
      run(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end

    div_begin = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
